i2cmb_multi_bus_monitor: RTL

//  Passive, parametrised monitor for NUM_BUSES I2C buses driven by the I2CMB DUT.

---
 rtl/i2cmb_multi_bus_monitor.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/i2cmb_multi_bus_monitor.sv
// Passive monitor for NUM_BUSES I2C buses: decodes START/RSTART/STOP/BYTE events per bus and
// merges them through round-robin arbitration into one first-word-fall-through record FIFO.
module i2cmb_multi_bus_monitor #(
    parameter int NUM_BUSES   = 16,
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 enable_i,
    input  logic [NUM_BUSES-1:0] scl_i,
    input  logic [NUM_BUSES-1:0] sda_i,
    output logic                 rec_valid_o,
    input  logic                 rec_ready_i,
    output logic [15:0]          rec_data_o,
    output logic [NUM_BUSES-1:0] busy_o,
    output logic [NUM_BUSES-1:0] overflow_o,
    input  logic                 overflow_clr_i
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [1:0] KIND_START  = 2'b00;
    localparam logic [1:0] KIND_RSTART = 2'b01;
    localparam logic [1:0] KIND_STOP   = 2'b10;
    localparam logic [1:0] KIND_BYTE   = 2'b11;

    typedef enum logic {IDLE, BITS} state_t;

    logic [NUM_BUSES-1:0] scl_sync [SYNC_STAGES];
    logic [NUM_BUSES-1:0] sda_sync [SYNC_STAGES];
    logic [NUM_BUSES-1:0] scl_now, sda_now, scl_prev, sda_prev;
    logic [NUM_BUSES-1:0] start_ev, stop_ev, rise_ev, sda_ev;

    state_t     state      [NUM_BUSES];
    state_t     state_next [NUM_BUSES];
    logic [3:0] bit_cnt      [NUM_BUSES];
    logic [3:0] bit_cnt_next [NUM_BUSES];
    logic [7:0] shift      [NUM_BUSES];
    logic [7:0] shift_next [NUM_BUSES];
    logic [NUM_BUSES-1:0] emit;
    logic [15:0]          emit_rec [NUM_BUSES];

    logic [NUM_BUSES-1:0] pend_valid, req, grant, overflow_set;
    logic [15:0]          pend_rec [NUM_BUSES];
    logic [3:0]           last_grant, grant_idx, scan_idx;
    logic                 push, pop, full, empty, can_push;

    logic [15:0]    mem [FIFO_DEPTH];
    logic [PTR_W:0] wr_ptr, rd_ptr;

    assign scl_now = scl_sync[SYNC_STAGES-1];
    assign sda_now = sda_sync[SYNC_STAGES-1];

    // Synchronisers reset to 1 so an idle bus never shows a false edge; events are registered.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                scl_sync[s] <= '1;
                sda_sync[s] <= '1;
            end
            scl_prev <= '1;
            sda_prev <= '1;
            start_ev <= '0;
            stop_ev  <= '0;
            rise_ev  <= '0;
            sda_ev   <= '1;
        end else begin
            scl_sync[0] <= scl_i;
            sda_sync[0] <= sda_i;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                scl_sync[s] <= scl_sync[s-1];
                sda_sync[s] <= sda_sync[s-1];
            end
            scl_prev <= scl_now;
            sda_prev <= sda_now;
            start_ev <= scl_now & scl_prev & ~sda_now & sda_prev;
            stop_ev  <= scl_now & scl_prev & sda_now & ~sda_prev;
            rise_ev  <= scl_now & ~scl_prev;
            sda_ev   <= sda_now;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int b = 0; b < NUM_BUSES; b++) begin
                state[b]   <= IDLE;
                bit_cnt[b] <= '0;
                shift[b]   <= '0;
            end
        end else begin
            for (int b = 0; b < NUM_BUSES; b++) begin
                state[b]   <= state_next[b];
                bit_cnt[b] <= bit_cnt_next[b];
                shift[b]   <= shift_next[b];
            end
        end
    end

    always_comb begin
        for (int b = 0; b < NUM_BUSES; b++) begin
            state_next[b] = state[b];
            if (!enable_i)
                state_next[b] = IDLE;
            else if (start_ev[b])
                state_next[b] = BITS;
            else if (stop_ev[b])
                state_next[b] = IDLE;
        end
    end

    // Bit 8 after a START is the ACK slot; any START/STOP discards the partial byte.
    always_comb begin
        emit   = '0;
        busy_o = '0;
        for (int b = 0; b < NUM_BUSES; b++) begin
            emit_rec[b]     = '0;
            bit_cnt_next[b] = bit_cnt[b];
            shift_next[b]   = shift[b];
            busy_o[b]       = (state[b] == BITS);
            if (!enable_i) begin
                bit_cnt_next[b] = '0;
            end else if (start_ev[b]) begin
                emit[b]         = 1'b1;
                emit_rec[b]     = {4'(b), (state[b] == BITS) ? KIND_RSTART : KIND_START, 10'd0};
                bit_cnt_next[b] = '0;
            end else if (stop_ev[b] && state[b] == BITS) begin
                emit[b]         = 1'b1;
                emit_rec[b]     = {4'(b), KIND_STOP, 10'd0};
                bit_cnt_next[b] = '0;
            end else if (rise_ev[b] && state[b] == BITS) begin
                if (bit_cnt[b] == 4'd8) begin
                    emit[b]         = 1'b1;
                    emit_rec[b]     = {4'(b), KIND_BYTE, ~sda_ev[b], 1'b0, shift[b]};
                    bit_cnt_next[b] = '0;
                end else begin
                    shift_next[b]   = {shift[b][6:0], sda_ev[b]};
                    bit_cnt_next[b] = bit_cnt[b] + 4'd1;
                end
            end
        end
    end

    // Round-robin scan begins just after the previously granted bus.
    always_comb begin
        req       = pend_valid & {NUM_BUSES{enable_i}};
        grant     = '0;
        grant_idx = last_grant;
        scan_idx  = '0;
        push      = 1'b0;
        if (can_push) begin
            for (int i = 1; i <= NUM_BUSES; i++) begin
                scan_idx = 4'((int'(last_grant) + i) % NUM_BUSES);
                if (!push && req[scan_idx]) begin
                    push      = 1'b1;
                    grant_idx = scan_idx;
                end
            end
        end
        if (push)
            grant[grant_idx] = 1'b1;
    end

    assign overflow_set = emit & pend_valid & ~grant;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_valid <= '0;
            overflow_o <= '0;
            last_grant <= 4'(NUM_BUSES - 1);
            for (int b = 0; b < NUM_BUSES; b++)
                pend_rec[b] <= '0;
        end else begin
            overflow_o <= (overflow_o & ~{NUM_BUSES{overflow_clr_i}}) | overflow_set;
            if (push)
                last_grant <= grant_idx;
            for (int b = 0; b < NUM_BUSES; b++) begin
                if (!enable_i) begin
                    pend_valid[b] <= 1'b0;
                end else if (emit[b] && (!pend_valid[b] || grant[b])) begin
                    pend_valid[b] <= 1'b1;
                    pend_rec[b]   <= emit_rec[b];
                end else if (grant[b]) begin
                    pend_valid[b] <= 1'b0;
                end
            end
        end
    end

    assign empty       = (wr_ptr == rd_ptr);
    assign full        = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                         (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign pop         = !empty && rec_ready_i;
    assign can_push    = !full || pop;
    assign rec_valid_o = !empty;
    assign rec_data_o  = empty ? 16'h0000 : mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push)
            mem[wr_ptr[PTR_W-1:0]] <= pend_rec[grant_idx];
    end
endmodule
